axi4lite_regbank: RTL and testbench

- Synthesizable AXI4-Lite slave register bank.
- It is the DUT that the team's AXI4-Lite master driver stimulates and the monitor observes.
- Provides NUM_CTRL read/write control registers and NUM_STAT read-only status registers, 32 bit each.
- Exposes the control registers as flat outputs with per-register write pulses; samples status inputs on read.

---
 rtl/axi4lite_types_pkg.sv | 15 +
 rtl/axi4lite_regbank.sv | 232 +++++++++++++++++++++++
 tb/tb_axi4lite_regbank.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_types_pkg.sv
// Shared AXI4-Lite definitions: response codes and bus widths used by the
// register bank and by the verification side.
package axi4lite_types_pkg;

    localparam int AXI4LITE_DATA_W = 32;
    localparam int AXI4LITE_STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_t;

endpackage

// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank: NUM_CTRL RW control registers followed by NUM_STAT RO status registers.
// Define AXI4LITE_REGBANK_SLVERR_EN to answer illegal writes and unmapped reads with SLVERR.
module axi4lite_regbank
    import axi4lite_types_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int NUM_CTRL = 8,
    parameter int NUM_STAT = 4
) (
    input  logic                                aclk,
    input  logic                                areset,

    input  logic [ADDR_W-1:0]                   s_axi_awaddr,
    input  logic                                s_axi_awvalid,
    output logic                                s_axi_awready,

    input  logic [AXI4LITE_DATA_W-1:0]          s_axi_wdata,
    input  logic [AXI4LITE_STRB_W-1:0]          s_axi_wstrb,
    input  logic                                s_axi_wvalid,
    output logic                                s_axi_wready,

    output logic [1:0]                          s_axi_bresp,
    output logic                                s_axi_bvalid,
    input  logic                                s_axi_bready,

    input  logic [ADDR_W-1:0]                   s_axi_araddr,
    input  logic                                s_axi_arvalid,
    output logic                                s_axi_arready,

    output logic [AXI4LITE_DATA_W-1:0]          s_axi_rdata,
    output logic [1:0]                          s_axi_rresp,
    output logic                                s_axi_rvalid,
    input  logic                                s_axi_rready,

    output logic [NUM_CTRL*AXI4LITE_DATA_W-1:0] ctrl_regs,
    output logic [NUM_CTRL-1:0]                 ctrl_wr_pulse,
    input  logic [NUM_STAT*AXI4LITE_DATA_W-1:0] stat_regs
);

    localparam int IDX_W = ADDR_W - 2;

`ifdef AXI4LITE_REGBANK_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    // Write channel state
    wr_state_t                    wr_state_reg;
    logic                         awready_reg;
    logic                         wready_reg;
    logic                         aw_have_reg;
    logic                         w_have_reg;
    logic [IDX_W-1:0]             awidx_reg;
    logic [AXI4LITE_DATA_W-1:0]   wdata_reg;
    logic [AXI4LITE_STRB_W-1:0]   wstrb_reg;
    logic                         bvalid_reg;
    logic [1:0]                   bresp_reg;
    logic [NUM_CTRL-1:0]          ctrl_wr_pulse_reg;
    logic [AXI4LITE_DATA_W-1:0]   ctrl_reg [NUM_CTRL];

    // Read channel state
    rd_state_t                    rd_state_reg;
    logic                         arready_reg;
    logic                         rvalid_reg;
    logic [AXI4LITE_DATA_W-1:0]   rdata_reg;
    logic [1:0]                   rresp_reg;

    logic                         wr_commit;
    logic [NUM_CTRL-1:0]          wr_sel;
    logic                         wr_hit;
    axi_resp_t                    bresp_next;
    logic [IDX_W-1:0]             rd_idx;
    logic [AXI4LITE_DATA_W-1:0]   rd_data_next;
    axi_resp_t                    rd_resp_next;
    logic                         rd_mapped;
    logic [AXI4LITE_DATA_W-1:0]   stat_word [NUM_STAT];
    logic                         unused_addr_lsb;

    // Byte offset within a word carries no meaning for this bank.
    assign unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // A write commits the cycle after both halves have been captured.
    assign wr_commit = (wr_state_reg == WR_IDLE) && aw_have_reg && w_have_reg;

    for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
        assign wr_sel[gi] = wr_commit && (awidx_reg == IDX_W'(gi));
        assign ctrl_regs[AXI4LITE_DATA_W*gi +: AXI4LITE_DATA_W] = ctrl_reg[gi];
    end

    for (genvar gi = 0; gi < NUM_STAT; gi++) begin : g_stat
        assign stat_word[gi] = stat_regs[AXI4LITE_DATA_W*gi +: AXI4LITE_DATA_W];
    end

    assign wr_hit = |wr_sel;

    always_comb begin
        bresp_next = OKAY;
        if (SLVERR_EN && !wr_hit) begin
            bresp_next = SLVERR;
        end
    end

    always_comb begin
        rd_idx       = s_axi_araddr[ADDR_W-1:2];
        rd_data_next = '0;
        rd_resp_next = OKAY;
        rd_mapped    = 1'b0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data_next = ctrl_reg[i];
                rd_mapped    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (rd_idx == IDX_W'(NUM_CTRL + j)) begin
                rd_data_next = stat_word[j];
                rd_mapped    = 1'b1;
            end
        end
        if (SLVERR_EN && !rd_mapped) begin
            rd_resp_next = SLVERR;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_reg      <= WR_IDLE;
            awready_reg       <= 1'b1;
            wready_reg        <= 1'b1;
            aw_have_reg       <= 1'b0;
            w_have_reg        <= 1'b0;
            awidx_reg         <= '0;
            wdata_reg         <= '0;
            wstrb_reg         <= '0;
            bvalid_reg        <= 1'b0;
            bresp_reg         <= OKAY;
            ctrl_wr_pulse_reg <= '0;
            for (int i = 0; i < NUM_CTRL; i++) begin
                ctrl_reg[i] <= '0;
            end
        end else begin
            ctrl_wr_pulse_reg <= '0;
            case (wr_state_reg)
                WR_IDLE: begin
                    if (awready_reg && s_axi_awvalid) begin
                        awidx_reg   <= s_axi_awaddr[ADDR_W-1:2];
                        aw_have_reg <= 1'b1;
                        awready_reg <= 1'b0;
                    end
                    if (wready_reg && s_axi_wvalid) begin
                        wdata_reg  <= s_axi_wdata;
                        wstrb_reg  <= s_axi_wstrb;
                        w_have_reg <= 1'b1;
                        wready_reg <= 1'b0;
                    end
                    if (wr_commit) begin
                        for (int i = 0; i < NUM_CTRL; i++) begin
                            if (wr_sel[i]) begin
                                for (int k = 0; k < AXI4LITE_STRB_W; k++) begin
                                    if (wstrb_reg[k]) begin
                                        ctrl_reg[i][8*k +: 8] <= wdata_reg[8*k +: 8];
                                    end
                                end
                            end
                        end
                        ctrl_wr_pulse_reg <= wr_sel;
                        bresp_reg         <= bresp_next;
                        bvalid_reg        <= 1'b1;
                        aw_have_reg       <= 1'b0;
                        w_have_reg        <= 1'b0;
                        wr_state_reg      <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_reg   <= 1'b0;
                        awready_reg  <= 1'b1;
                        wready_reg   <= 1'b1;
                        wr_state_reg <= WR_IDLE;
                    end
                end
                default: wr_state_reg <= WR_IDLE;
            endcase
        end
    end

    // Read data is sampled on the AR handshake edge, so a same-edge write is not yet visible.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state_reg <= RD_IDLE;
            arready_reg  <= 1'b1;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= OKAY;
        end else begin
            case (rd_state_reg)
                RD_IDLE: begin
                    if (arready_reg && s_axi_arvalid) begin
                        rdata_reg    <= rd_data_next;
                        rresp_reg    <= rd_resp_next;
                        rvalid_reg   <= 1'b1;
                        arready_reg  <= 1'b0;
                        rd_state_reg <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (s_axi_rready) begin
                        rvalid_reg   <= 1'b0;
                        arready_reg  <= 1'b1;
                        rd_state_reg <= RD_IDLE;
                    end
                end
                default: rd_state_reg <= RD_IDLE;
            endcase
        end
    end

    assign s_axi_awready = awready_reg;
    assign s_axi_wready  = wready_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bresp   = bresp_reg;
    assign s_axi_arready = arready_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = rresp_reg;
    assign ctrl_wr_pulse = ctrl_wr_pulse_reg;

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Self-checking bench for axi4lite_regbank: directed protocol cases plus randomized
// reads/writes against an array-based register model.
`timescale 1ns/1ps
module tb_axi4lite_regbank;
    import axi4lite_types_pkg::*;

    localparam int ADDR_W   = 8;
    localparam int NUM_CTRL = 8;
    localparam int NUM_STAT = 4;

`ifdef AXI4LITE_REGBANK_SLVERR_EN
    localparam bit SLVERR_ON = 1'b1;
`else
    localparam bit SLVERR_ON = 1'b0;
`endif

    logic                     aclk = 1'b0;
    logic                     areset;
    logic [ADDR_W-1:0]        s_axi_awaddr;
    logic                     s_axi_awvalid;
    logic                     s_axi_awready;
    logic [31:0]              s_axi_wdata;
    logic [3:0]               s_axi_wstrb;
    logic                     s_axi_wvalid;
    logic                     s_axi_wready;
    logic [1:0]               s_axi_bresp;
    logic                     s_axi_bvalid;
    logic                     s_axi_bready;
    logic [ADDR_W-1:0]        s_axi_araddr;
    logic                     s_axi_arvalid;
    logic                     s_axi_arready;
    logic [31:0]              s_axi_rdata;
    logic [1:0]               s_axi_rresp;
    logic                     s_axi_rvalid;
    logic                     s_axi_rready;
    logic [NUM_CTRL*32-1:0]   ctrl_regs;
    logic [NUM_CTRL-1:0]      ctrl_wr_pulse;
    logic [NUM_STAT*32-1:0]   stat_regs;

    always #5 aclk = ~aclk;

    axi4lite_regbank #(.ADDR_W(ADDR_W), .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse), .stat_regs(stat_regs)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ctrl_model [NUM_CTRL];
    logic [31:0] stat_model [NUM_STAT];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] exp_wresp(input logic [7:0] addr);
        int idx;
        idx = int'(addr[7:2]);
        return (SLVERR_ON && idx >= NUM_CTRL) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr[7:2]);
        if (idx < NUM_CTRL) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) ctrl_model[idx][8*k +: 8] = data[8*k +: 8];
            end
        end
    endtask

    task automatic model_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int idx;
        idx  = int'(addr[7:2]);
        resp = 2'b00;
        if (idx < NUM_CTRL) data = ctrl_model[idx];
        else if (idx < NUM_CTRL + NUM_STAT) data = stat_model[idx - NUM_CTRL];
        else begin
            data = 32'h0;
            if (SLVERR_ON) resp = 2'b10;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CTRL; i++) ctrl_model[i] = 32'h0;
    endtask

    task automatic set_stat(input int j, input logic [31:0] v);
        stat_model[j] = v;
        stat_regs[32*j +: 32] = v;
    endtask

    task automatic check_all_ctrl(input string tag);
        for (int i = 0; i < NUM_CTRL; i++) check(tag, ctrl_regs[32*i +: 32], ctrl_model[i]);
    endtask

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done, w_done, hs_aw, hs_w;
        int cyc, idx;
        logic [NUM_CTRL-1:0] exp_pulse;
        logic [1:0] exp_resp;
        aw_done = 0; w_done = 0; cyc = 0;
        idx = int'(addr[7:2]);
        exp_pulse = (idx < NUM_CTRL) ? (NUM_CTRL'(1) << idx) : '0;
        exp_resp  = exp_wresp(addr);
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge aclk);
            s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            s_axi_awaddr  = addr;
            s_axi_wvalid  = !w_done && (cyc >= w_dly);
            s_axi_wdata   = data;
            s_axi_wstrb   = strb;
            hs_aw = s_axi_awvalid && s_axi_awready;
            hs_w  = s_axi_wvalid && s_axi_wready;
            @(posedge aclk);
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            cyc++;
        end
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 0, 1);
            return;
        end
        check("wr_bvalid_early", s_axi_bvalid, 0);
        @(negedge aclk);
        model_write(addr, data, strb);
        check("wr_bvalid", s_axi_bvalid, 1);
        check("wr_bresp", s_axi_bresp, exp_resp);
        check("wr_pulse", ctrl_wr_pulse, exp_pulse);
        check_all_ctrl("wr_ctrl_regs");
        for (int k = 0; k < b_dly; k++) begin
            @(negedge aclk);
            check("wr_hold_bvalid", s_axi_bvalid, 1);
            check("wr_hold_bresp", s_axi_bresp, exp_resp);
            check("wr_hold_ready", {s_axi_awready, s_axi_wready}, 2'b00);
            check("wr_hold_pulse", ctrl_wr_pulse, 0);
        end
        s_axi_bready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0;
        check("wr_bvalid_done", s_axi_bvalid, 0);
        check("wr_ready_back", {s_axi_awready, s_axi_wready}, 2'b11);
        check("wr_pulse_clear", ctrl_wr_pulse, 0);
        $display("[TB] WR addr=%02h data=%08h strb=%h aw_dly=%0d w_dly=%0d b_dly=%0d resp=%0d",
                 addr, data, strb, aw_dly, w_dly, b_dly, exp_resp);
    endtask

    task automatic axi_read(input logic [7:0] addr, input int ar_dly, input int r_dly);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit done, hs;
        int cyc;
        done = 0; cyc = 0;
        model_read(addr, exp_data, exp_resp);
        while (!done && cyc < 50) begin
            @(negedge aclk);
            s_axi_arvalid = (cyc >= ar_dly);
            s_axi_araddr  = addr;
            hs = s_axi_arvalid && s_axi_arready;
            @(posedge aclk);
            done = hs;
            cyc++;
        end
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        if (!done) begin
            check("rd_handshake_timeout", 0, 1);
            return;
        end
        check("rd_rvalid", s_axi_rvalid, 1);
        check("rd_rdata", s_axi_rdata, exp_data);
        check("rd_rresp", s_axi_rresp, exp_resp);
        check("rd_arready_low", s_axi_arready, 0);
        for (int k = 0; k < r_dly; k++) begin
            @(negedge aclk);
            check("rd_hold_rvalid", s_axi_rvalid, 1);
            check("rd_hold_rdata", s_axi_rdata, exp_data);
            check("rd_hold_rresp", s_axi_rresp, exp_resp);
            check("rd_hold_arready", s_axi_arready, 0);
        end
        s_axi_rready = 1'b1;
        @(negedge aclk);
        s_axi_rready = 1'b0;
        check("rd_rvalid_done", s_axi_rvalid, 0);
        check("rd_arready_back", s_axi_arready, 1);
        $display("[TB] RD addr=%02h data=%08h resp=%0d ar_dly=%0d r_dly=%0d",
                 addr, exp_data, exp_resp, ar_dly, r_dly);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a;
        int r;
        areset = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
        s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
        stat_regs = '0;
        for (int j = 0; j < NUM_STAT; j++) stat_model[j] = 32'h0;
        model_reset();
        repeat (3) @(negedge aclk);
        areset = 1'b0;

        // Reset state
        check("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        check("rst_valid", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        check("rst_resp", {s_axi_bresp, s_axi_rresp}, 4'h0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_pulse", ctrl_wr_pulse, 0);
        check_all_ctrl("rst_ctrl");

        // Same-cycle AW/W, then W leading AW by 3 cycles with a single byte strobe
        axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        axi_write(8'h04, 32'h000000AA, 4'h1, 3, 0, 0);
        axi_read(8'h04, 0, 0);
        check("deadbeaa", ctrl_regs[63:32], 32'hDEADBEAA);

        // Status read and illegal write to a status index
        set_stat(0, 32'h12345678);
        axi_read(8'h20, 0, 0);
        axi_write(8'h20, 32'hCAFEF00D, 4'hF, 1, 0, 0);
        axi_read(8'h20, 0, 0);

        // Unmapped read
        axi_read(8'hFC, 0, 0);

        // Back-pressure on both response channels
        axi_write(8'h0C, 32'h01020304, 4'hA, 0, 2, 5);
        axi_read(8'h0C, 1, 5);

        // Reset with AW captured but W pending
        @(negedge aclk);
        s_axi_awaddr  = 8'h08;
        s_axi_awvalid = 1'b1;
        check("mid_aw_ready", s_axi_awready, 1);
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        model_reset();
        check("mid_rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        check("mid_rst_bvalid", s_axi_bvalid, 0);
        check_all_ctrl("mid_rst_ctrl");
        s_axi_wdata  = 32'h55AA55AA;
        s_axi_wstrb  = 4'hF;
        s_axi_wvalid = 1'b1;
        @(negedge aclk);
        s_axi_wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("w_alone_bvalid", s_axi_bvalid, 0);
            check("w_alone_pulse", ctrl_wr_pulse, 0);
            @(negedge aclk);
        end
        check_all_ctrl("w_alone_ctrl");
        do_reset();

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 19);
            a[7:2] = (r < 16) ? 6'(r) : 6'($urandom_range(16, 63));
            a[1:0] = 2'($urandom);
            if ($urandom_range(0, 3) == 0)
                set_stat($urandom_range(0, NUM_STAT - 1), $urandom);
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            else
                axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
